// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: N-way set-associative write-back/write-allocate cache controller with tree PLRU
module sa_cache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 1024,
  parameter int WAYS       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_valid,
  input  logic                         cpu_rw,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [WORD_W-1:0]            cpu_wdata,
  output logic                         cpu_ready,
  output logic [WORD_W-1:0]            cpu_rdata,
  output logic                         cpu_busy,
  output logic                         mem_valid,
  output logic                         mem_rw,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [LINE_WORDS*WORD_W-1:0] mem_wdata,
  input  logic                         mem_ready,
  input  logic [LINE_WORDS*WORD_W-1:0] mem_rdata
);
  localparam int BO  = $clog2(WORD_W/8);
  localparam int OFF = $clog2(LINE_WORDS*WORD_W/8);
  localparam int IW  = $clog2(SETS);
  localparam int TW  = ADDR_W-OFF-IW;
  localparam int WS  = $clog2(LINE_WORDS);
  localparam int LW  = LINE_WORDS*WORD_W;
  localparam int L   = $clog2(WAYS);
  localparam int VW  = WAYS > 1 ? L : 1;
  localparam int PW  = WAYS > 1 ? WAYS-1 : 1;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [VW-1:0] w);
    int n = 1;
    for (int l = 0; l < L; l++) begin
      p[n-1] = ~w[L-1-l];
      n = 2*n + int'(w[L-1-l]);
    end
    return p;
  endfunction
  function automatic logic [VW-1:0] plru_victim(input logic [PW-1:0] p);
    logic [VW-1:0] v = '0;
    int n = 1;
    for (int l = 0; l < L; l++) begin
      v[L-1-l] = p[n-1];
      n = 2*n + int'(p[n-1]);
    end
    return v;
  endfunction
  state_t          r_state, w_next;
  logic            r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [VW-1:0]   r_vic;
  logic [TW-1:0]   r_tag  [WAYS][SETS];
  logic [LW-1:0]   r_data [WAYS][SETS];
  logic [WAYS-1:0] r_valid [SETS];
  logic [WAYS-1:0] r_dirty [SETS];
  logic [PW-1:0]   r_plru  [SETS];
  logic [IW-1:0]   w_idx;
  logic [TW-1:0]   w_tag;
  logic [WS-1:0]   w_wsel;
  logic            w_hit, w_inv, w_unused;
  logic [VW-1:0]   w_hit_way, w_inv_way, w_vic;
  logic [LW-1:0]   w_line, w_merged;
  logic [WORD_W-1:0] w_rword;
  assign w_idx    = r_addr[OFF +: IW];
  assign w_tag    = r_addr[ADDR_W-1 -: TW];
  assign w_wsel   = r_addr[BO +: WS];
  assign w_unused = ^r_addr[BO-1:0];
  assign w_line   = r_data[w_hit_way][w_idx];
  assign w_rword  = w_line[w_wsel*WORD_W +: WORD_W];
  assign w_vic    = w_inv ? w_inv_way : plru_victim(r_plru[w_idx]);
  assign cpu_busy = r_state != IDLE;
  // Parallel tag compare plus lowest-numbered invalid way search
  always_comb begin
    w_hit = 1'b0;
    w_hit_way = '0;
    w_inv = 1'b0;
    w_inv_way = '0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (r_valid[w_idx][i] && r_tag[i][w_idx] == w_tag) begin
        w_hit = 1'b1;
        w_hit_way = VW'(i);
      end
      if (!r_valid[w_idx][i]) begin
        w_inv = 1'b1;
        w_inv_way = VW'(i);
      end
    end
  end
  // Store word merged into the hit line
  always_comb begin
    w_merged = w_line;
    w_merged[w_wsel*WORD_W +: WORD_W] = r_wdata;
  end
  // Next state and all outputs; memory outputs depend only on held registers so they stay stable
  always_comb begin
    w_next = r_state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_valid = 1'b0;
    mem_rw = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: w_next = cpu_valid ? COMPARE : IDLE;
      COMPARE: begin
        cpu_ready = w_hit;
        cpu_rdata = w_hit ? w_rword : '0;
        w_next = w_hit ? IDLE : (r_valid[w_idx][w_vic] && r_dirty[w_idx][w_vic]) ? WRITE_BACK : ALLOCATE;
      end
      WRITE_BACK: begin
        mem_valid = 1'b1;
        mem_rw = 1'b1;
        mem_addr = {r_tag[r_vic][w_idx], w_idx, {OFF{1'b0}}};
        mem_wdata = r_data[r_vic][w_idx];
        w_next = mem_ready ? ALLOCATE : WRITE_BACK;
      end
      default: begin
        mem_valid = 1'b1;
        mem_addr = {w_tag, w_idx, {OFF{1'b0}}};
        w_next = mem_ready ? COMPARE : ALLOCATE;
      end
    endcase
  end
  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // Latch the request on acceptance and the victim way on a miss
  always_ff @(posedge clk) begin
    if (r_state == IDLE && cpu_valid) begin
      r_rw <= cpu_rw;
      r_addr <= cpu_addr;
      r_wdata <= cpu_wdata;
    end
    if (r_state == COMPARE && !w_hit) r_vic <= w_vic;
  end
  // Valid, dirty and PLRU bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s] <= '0;
      end
    end else if (r_state == COMPARE && w_hit) begin
      r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
      if (r_rw) r_dirty[w_idx][w_hit_way] <= 1'b1;
    end else if (r_state == WRITE_BACK && mem_ready) begin
      r_dirty[w_idx][r_vic] <= 1'b0;
    end else if (r_state == ALLOCATE && mem_ready) begin
      r_valid[w_idx][r_vic] <= 1'b1;
      r_dirty[w_idx][r_vic] <= 1'b0;
    end
  end
  // Tag and data arrays: line fill on allocate, word merge on a write hit
  always_ff @(posedge clk) begin
    if (r_state == ALLOCATE && mem_ready) begin
      r_tag[r_vic][w_idx] <= w_tag;
      r_data[r_vic][w_idx] <= mem_rdata;
    end else if (r_state == COMPARE && w_hit && r_rw) begin
      r_data[w_hit_way][w_idx] <= w_merged;
    end
  end
endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb_sa_cache_ctrl: directed plus randomized checks of sa_cache_ctrl against a set/way reference model
module tb_sa_cache_ctrl;
  logic clk = 1'b0, rst = 1'b1, cpu_valid = 1'b0, cpu_rw = 1'b0, mem_ready = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata, mem_addr, last_rd;
  logic cpu_ready, cpu_busy, mem_valid, mem_rw;
  logic [127:0] mem_wdata, mem_rdata = '0;
  int checks = 0, errors = 0;
  logic [127:0] bus_mem [logic [31:0]];
  logic [127:0] ref_mem [logic [31:0]];
  bit m_valid [4][2];
  bit m_dirty [4][2];
  logic [25:0] m_tag [4][2];
  logic [127:0] m_line [4][2];
  int m_vptr [4];
  always #5 clk = ~clk;
  sa_cache_ctrl #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(4), .SETS(4), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );
  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a + 32'd3, a + 32'd2, a + 32'd1, a} ^ {4{32'hC0DE0000}};
  endfunction
  function automatic logic [127:0] bus_get(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : pat(a);
  endfunction
  function automatic logic [127:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_vptr[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask
  // kind: 0 hit, 1 clean miss, 2 dirty miss
  task automatic model(input logic rw, input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd,
                       output int kind, output logic [31:0] wb_a, output logic [127:0] wb_d, output logic [31:0] fill_a);
    int s = int'(a[5:4]);
    int k = int'(a[3:2]);
    logic [25:0] t = a[31:6];
    int w = -1;
    kind = 0;
    wb_a = '0;
    wb_d = '0;
    fill_a = '0;
    for (int i = 0; i < 2; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
    if (w < 0) begin
      w = !m_valid[s][0] ? 0 : !m_valid[s][1] ? 1 : m_vptr[s];
      kind = 1;
      fill_a = {a[31:4], 4'b0};
      if (m_valid[s][w] && m_dirty[s][w]) begin
        kind = 2;
        wb_a = {m_tag[s][w], a[5:4], 4'b0};
        wb_d = m_line[s][w];
        ref_mem[wb_a] = wb_d;
      end
      m_line[s][w] = ref_get(fill_a);
      m_tag[s][w] = t;
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
    end
    rd = m_line[s][w][k*32 +: 32];
    if (rw) begin
      m_line[s][w][k*32 +: 32] = wd;
      m_dirty[s][w] = 1'b1;
    end
    m_vptr[s] = 1 - w;
  endtask
  task automatic do_req(input logic rw, input logic [31:0] a, input logic [31:0] wd, input int dly);
    logic [31:0] e_rd, e_wba, e_fa;
    logic [127:0] e_wbd;
    int kind, exp_lat, n = 0, w = 0, nt = 0;
    logic t_rw [2];
    logic [31:0] t_a [2];
    logic [127:0] t_d [2];
    bit done = 1'b0;
    model(rw, a, wd, e_rd, kind, e_wba, e_wbd, e_fa);
    exp_lat = kind == 0 ? 1 : kind == 1 ? 3 + dly : 4 + 2*dly;
    cpu_valid = 1'b1;
    cpu_rw = rw;
    cpu_addr = a;
    cpu_wdata = wd;
    @(negedge clk);
    cpu_valid = 1'b0;
    cpu_rw = 1'($urandom);
    cpu_addr = $urandom;
    cpu_wdata = $urandom;
    while (!done && n < 100) begin
      n++;
      if (cpu_ready) begin
        done = 1'b1;
        last_rd = cpu_rdata;
      end else begin
        check("busy_wait", cpu_busy, 1);
        if (mem_valid) begin
          if (w == 0) begin
            if (nt < 2) begin
              t_rw[nt] = mem_rw;
              t_a[nt] = mem_addr;
              t_d[nt] = mem_wdata;
            end
            nt++;
          end else if (nt <= 2) begin
            check("stable_addr", mem_addr, t_a[nt-1]);
            check("stable_rw", mem_rw, t_rw[nt-1]);
          end
          if (w == dly) begin
            mem_ready = 1'b1;
            if (mem_rw) bus_mem[mem_addr] = mem_wdata;
            else mem_rdata = bus_get(mem_addr);
            w = 0;
          end else w++;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    check("completed", done, 1);
    check("latency", n, exp_lat);
    if (!rw) check("rdata", last_rd, e_rd);
    check("mem_txn_count", nt, kind);
    if (kind == 2) begin
      check("wb_rw", t_rw[0], 1);
      check("wb_addr", t_a[0], e_wba);
      check("wb_data", t_d[0], e_wbd);
    end
    if (kind > 0) begin
      check("fill_rw", t_rw[kind-1], 0);
      check("fill_addr", t_a[kind-1], e_fa);
    end
    @(negedge clk);
    check("back_idle", {cpu_busy, cpu_ready, mem_valid}, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  initial begin
    int hit_seen;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", cpu_ready, 0);
    check("rst_busy", cpu_busy, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_rw", mem_rw, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    bus_mem[32'h010] = {32'h44, 32'h33, 32'h22, 32'h11};
    ref_mem[32'h010] = {32'h44, 32'h33, 32'h22, 32'h11};
    do_req(1'b0, 32'h010, 32'h0, 2);
    check("t1_rdata", last_rd, 32'h11);
    do_req(1'b1, 32'h014, 32'hDEADBEEF, 1);
    do_req(1'b0, 32'h014, 32'h0, 1);
    check("t2_rdata", last_rd, 32'hDEADBEEF);
    do_req(1'b0, 32'h010, 32'h0, 0);
    do_req(1'b0, 32'h050, 32'h0, 1);
    do_req(1'b0, 32'h010, 32'h0, 0);
    do_req(1'b0, 32'h090, 32'h0, 2);
    do_req(1'b0, 32'h010, 32'h0, 0);
    do_reset();
    do_req(1'b1, 32'h010, 32'h11111111, 1);
    do_req(1'b0, 32'h050, 32'h0, 0);
    do_req(1'b0, 32'h050, 32'h0, 0);
    do_req(1'b0, 32'h090, 32'h0, 2);
    do_req(1'b0, 32'h010, 32'h0, 1);
    check("t4_rdata", last_rd, 32'h11111111);
    do_req(1'b0, 32'h0D0, 32'h0, 5);
    do_reset();
    do_req(1'b0, 32'h010, 32'h0, 0);
    cpu_valid = 1'b1;
    cpu_rw = 1'b0;
    cpu_addr = 32'h290;
    @(negedge clk);
    cpu_valid = 1'b0;
    hit_seen = 0;
    for (int i = 0; i < 20 && hit_seen == 0; i++) begin
      if (mem_valid && !mem_rw) hit_seen = 1;
      else @(negedge clk);
    end
    check("rst_reach_alloc", hit_seen, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem_valid", mem_valid, 0);
    check("abort_busy", cpu_busy, 0);
    check("abort_ready", cpu_ready, 0);
    rst = 1'b0;
    model_reset();
    do_req(1'b0, 32'h010, 32'h0, 1);
    do_reset();
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 3)) << 6) |
          (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      do_req(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_cache_ctrl.md
Name: sa_cache_ctrl

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache controller with built-in tag/valid/dirty/data arrays and tree pseudo-LRU replacement.
- Sits between one CPU load/store port and a line-wide memory port.
- Successor to the direct-mapped cache FSM: configurable geometry and associativity, request latching, and full memory handshake.

Parameters:
- ADDR_W, 32, byte address width.
- WORD_W, 32, CPU word width in bits. Power of 2, at least 8.
- LINE_WORDS, 4, words per line. Power of 2, at least 2.
- SETS, 1024, number of sets. Power of 2, at least 2.
- WAYS, 2, associativity. Power of 2, 1 to 8. WAYS=1 degenerates to direct-mapped with no LRU state.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_valid  in  1  CPU request present; sampled only in IDLE.
- cpu_rw  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address, word aligned.
- cpu_wdata  in  WORD_W  store data.
- cpu_ready  out  1  one-cycle pulse: request complete.
- cpu_rdata  out  WORD_W  load data; valid while cpu_ready=1.
- cpu_busy  out  1  high when state is not IDLE.
- mem_valid  out  1  memory request; held until accepted.
- mem_rw  out  1  1 = line write, 0 = line read.
- mem_addr  out  ADDR_W  line-aligned address; offset bits are 0.
- mem_wdata  out  LINE_WORDS*WORD_W  write-back line; word 0 in the LSBs.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_rdata  in  LINE_WORDS*WORD_W  fill line; valid with mem_ready.

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS*WORD_W/8).
  - index = addr[OFF +: log2(SETS)].
  - tag = remaining upper bits.
  - word select = addr[OFF-1 : log2(WORD_W/8)].
- Reset:
  - state goes to IDLE; all valid, dirty and PLRU bits clear.
  - cpu_ready=0, cpu_busy=0, mem_valid=0.
  - cpu_rdata, mem_addr, mem_rw and mem_wdata are 0.
  - Tag and data arrays are not reset.
  - rst asserted in any state, including mid-transaction, aborts the transaction. The request is dropped without cpu_ready, and mem_valid is 0 in the following cycle.
- IDLE: if cpu_valid=1, latch addr, rw and wdata into request registers and go to COMPARE. The CPU may change its inputs afterwards.
- COMPARE: all ways of the indexed set are compared in parallel; hit means valid && tag match.
  - On a hit:
    - cpu_ready=1 and cpu_rdata = selected word from the hit way.
    - On a write, merge the word into the line and set dirty.
    - Update PLRU toward the hit way, then go to IDLE.
  - On a miss, choose the victim way:
    - the lowest-numbered invalid way if one exists;
    - otherwise the PLRU victim.
  - If the victim is valid and dirty, go to WRITE_BACK. Otherwise go to ALLOCATE.
- WRITE_BACK:
  - Drive mem_valid=1, mem_rw=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line.
  - On mem_ready, clear the victim's dirty bit and go to ALLOCATE.
- ALLOCATE:
  - Drive mem_valid=1, mem_rw=0, mem_addr = request line address.
  - On mem_ready, write mem_rdata, the new tag, valid=1 and dirty=0 into the victim way, then return to COMPARE. COMPARE now hits and completes the read or merges the write.
- Memory handshake:
  - mem_* outputs stay stable while mem_valid=1 and mem_ready=0.
  - mem_ready may arrive in the first request cycle.
  - mem_ready is ignored outside WRITE_BACK and ALLOCATE.
- Latency, with acceptance in cycle N:
  - hit: cpu_ready in N+1.
  - clean miss: cpu_ready 1 cycle after the fill's mem_ready.
  - dirty miss: adds a write-back handshake before the fill.
- PLRU:
  - WAYS-1 tree bits per set; a node bit of 0 points to the lower half.
  - On each access, set every node on the path to point away from the accessed way.
  - Victim = follow the node bits from the root.
- cpu_valid held high across cpu_ready starts a new request only when the controller is back in IDLE, i.e. one cycle after cpu_ready. There are no back-to-back hits.

Test Plan:
(All tests use WAYS=2, SETS=4, LINE_WORDS=4, WORD_W=32, so index = addr[5:4].)
- Cold read 0x010, memory returns the line 0x44,0x33,0x22,0x11 (word3 first), mem_ready 2 cycles after mem_valid -> mem_rw=0, mem_addr=0x010; cpu_ready 1 cycle after mem_ready with cpu_rdata=0x11.
- After test 1, write 0x014=0xDEADBEEF, then read 0x014 -> each request gives cpu_ready 1 cycle after acceptance; read returns 0xDEADBEEF; mem_valid stays 0 throughout.
- Sequence: read 0x010, read 0x050, read 0x010, read 0x090 (all set 1) -> the 0x090 fill replaces the 0x050 way; a following read of 0x010 hits with no memory traffic.
- Sequence: write 0x010=0x11111111, read 0x050, read 0x050, read 0x090 -> a write-back with mem_rw=1, mem_addr=0x010 and mem_wdata[31:0]=0x11111111 comes first, then a read of 0x090. A later read of 0x010 misses and returns 0x11111111.
- Hold mem_ready low for 5 cycles in ALLOCATE -> mem_valid, mem_addr and mem_rw are stable all 5 cycles; cpu_ready=0 and cpu_busy=1.
- Assert rst for 1 cycle mid-ALLOCATE -> next cycle mem_valid=0 and cpu_busy=0 with no cpu_ready; a later read of a previously cached 0x010 misses.
